// File: rtl/ahb5_sram_excl_responder_pkg.sv
// Shared AHB5 encodings, responder FSM states and byte-lane helper.
package ahb5_sram_excl_responder_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: return 4'b0001 << off;
      HSIZE_HALF: return 4'b0011 << {off[1], 1'b0};
      HSIZE_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahb5_sram_excl_responder_if.sv
// AHB5 manager/subordinate signal bundle for the SRAM responder.
interface ahb5_sram_excl_responder_if #(
  parameter int unsigned W_ADDR = 32,
  parameter int unsigned W_DATA = 32
);
  logic              hsel;
  logic              hready;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic              hexcl;
  logic [7:0]        hmaster;
  logic [W_DATA-1:0] hwdata;
  logic              hreadyout;
  logic              hresp;
  logic              hexokay;
  logic [W_DATA-1:0] hrdata;

  modport master (
    output hsel, hready, haddr, hwrite, htrans, hsize, hexcl, hmaster, hwdata,
    input  hreadyout, hresp, hexokay, hrdata
  );

  modport slave (
    input  hsel, hready, haddr, hwrite, htrans, hsize, hexcl, hmaster, hwdata,
    output hreadyout, hresp, hexokay, hrdata
  );
endinterface

// File: rtl/ahb5_sram_excl_responder_excl_monitor.sv
// Exclusive-access reservation table: one {valid, word} entry per manager index.
module ahb5_excl_monitor #(
  parameter int unsigned N_MONITORS = 2,
  parameter int unsigned W_WORD     = 10,
  parameter int unsigned W_IDX      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W_IDX-1:0]  idx_i,
  input  logic [W_WORD-1:0] word_i,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic              wr_i,
  output logic              pass_o
);
  logic [N_MONITORS-1:0] valid_q, valid_d;
  logic [W_WORD-1:0]     word_q [N_MONITORS];
  logic [W_WORD-1:0]     word_d [N_MONITORS];

  // The owner's set beats any clear aimed at the same entry in the same cycle.
  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    pass_o  = 1'b0;
    for (int unsigned i = 0; i < N_MONITORS; i++) begin
      if (set_i && idx_i == W_IDX'(i)) begin
        valid_d[i] = 1'b1;
        word_d[i]  = word_i;
      end else if ((clr_i && idx_i == W_IDX'(i)) || (wr_i && word_q[i] == word_i)) begin
        valid_d[i] = 1'b0;
      end
      if (idx_i == W_IDX'(i)) pass_o = valid_q[i] && (word_q[i] == word_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < N_MONITORS; i++) word_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      word_q  <= word_d;
    end
  end
endmodule

// File: rtl/ahb5_sram_excl_responder.sv
// AHB5 word-organised SRAM subordinate with wait states, ERROR responses and
// an exclusive monitor driving HEXOKAY.
module ahb5_sram_excl_responder
  import ahb5_sram_excl_responder_pkg::*;
#(
  parameter int unsigned W_ADDR      = 32,
  parameter int unsigned W_DATA      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned N_MONITORS  = 2
) (
  input logic clk,
  input logic rst,
  ahb5_sram_excl_responder_if.slave ahb
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (N_MONITORS > 1) ? $clog2(N_MONITORS) : 1;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [W_ADDR-1:0] ADDR_LIMIT = W_ADDR'(DEPTH * 4);

  logic [W_DATA-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [AW-1:0]     a_word_q, a_word_d;
  logic [1:0]        a_off_q, a_off_d;
  logic [2:0]        a_size_q, a_size_d;
  logic              a_write_q, a_write_d;
  logic              a_excl_q, a_excl_d;
  logic [IW-1:0]     a_idx_q, a_idx_d;
  logic [W_DATA-1:0] hrdata_q, hrdata_d;

  logic              acc, err, done, wr_perf, rd_issue, mon_pass;
  logic [AW-1:0]     rd_word;
  logic [W_DATA-1:0] rd_merged;
  logic [3:0]        be;
  logic              unused_bits;

  assign unused_bits = ^{ahb.htrans[0], ahb.hmaster[7:IW]};

  assign acc = ahb.hsel && ahb.hready && ahb.htrans[1] &&
               (state_q == ST_IDLE || state_q == ST_ERR2);
  assign err = (ahb.hsize > HSIZE_WORD) ||
               (ahb.hsize == HSIZE_HALF && ahb.haddr[0]) ||
               (ahb.hsize == HSIZE_WORD && ahb.haddr[1:0] != 2'b00) ||
               (ahb.haddr >= ADDR_LIMIT);
  assign done    = (state_q == ST_IDLE) && pend_q;
  assign be      = be_from_size(a_size_q, a_off_q);
  assign wr_perf = done && a_write_q && (!a_excl_q || mon_pass);

  // Read port: issued at address phase with no wait states, else in the last
  // WAIT cycle; bytes of a write completing this cycle are forwarded.
  always_comb begin
    rd_issue = 1'b0;
    rd_word  = a_word_q;
    if (WAIT_CYCLES == 0) begin
      rd_issue = acc && !err && !ahb.hwrite;
      rd_word  = ahb.haddr[AW+1:2];
    end else begin
      rd_issue = (state_q == ST_WAIT) && (cnt_q == 4'd0) && !a_write_q;
    end
    rd_merged = mem[rd_word];
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_perf && a_word_q == rd_word && be[b]) rd_merged[b*8 +: 8] = ahb.hwdata[b*8 +: 8];
    end
    hrdata_d = rd_issue ? rd_merged : hrdata_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    a_word_d  = a_word_q;
    a_off_d   = a_off_q;
    a_size_d  = a_size_q;
    a_write_d = a_write_q;
    a_excl_d  = a_excl_q;
    a_idx_d   = a_idx_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
        if (acc) begin
          if (err) begin
            state_d = ST_ERR1;
          end else begin
            pend_d    = 1'b1;
            a_word_d  = ahb.haddr[AW+1:2];
            a_off_d   = ahb.haddr[1:0];
            a_size_d  = ahb.hsize;
            a_write_d = ahb.hwrite;
            a_excl_d  = ahb.hexcl;
            a_idx_d   = ahb.hmaster[IW-1:0];
            if (WAIT_CYCLES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      a_word_q  <= '0;
      a_off_q   <= '0;
      a_size_q  <= '0;
      a_write_q <= 1'b0;
      a_excl_q  <= 1'b0;
      a_idx_q   <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      a_word_q  <= a_word_d;
      a_off_q   <= a_off_d;
      a_size_q  <= a_size_d;
      a_write_q <= a_write_d;
      a_excl_q  <= a_excl_d;
      a_idx_q   <= a_idx_d;
      hrdata_q  <= hrdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_perf) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[a_word_q][b*8 +: 8] <= ahb.hwdata[b*8 +: 8];
      end
    end
  end

  ahb5_excl_monitor #(
    .N_MONITORS(N_MONITORS),
    .W_WORD    (AW),
    .W_IDX     (IW)
  ) u_mon (
    .clk   (clk),
    .rst   (rst),
    .idx_i (a_idx_q),
    .word_i(a_word_q),
    .set_i (done && a_excl_q && !a_write_q),
    .clr_i (done && a_excl_q && a_write_q),
    .wr_i  (wr_perf),
    .pass_o(mon_pass)
  );

  assign ahb.hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign ahb.hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign ahb.hexokay   = done && a_excl_q && (!a_write_q || mon_pass);
  assign ahb.hrdata    = hrdata_q;
endmodule

// File: tb/tb_ahb5_sram_excl_responder.sv
// Directed bench: zero-wait instance for data/error/exclusive paths, two-wait instance for stalls.
module tb_ahb5_sram_excl_responder;
  import ahb5_sram_excl_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ahb5_sram_excl_responder_if #(.W_ADDR(32), .W_DATA(32)) b0 ();
  ahb5_sram_excl_responder_if #(.W_ADDR(32), .W_DATA(32)) b2 ();

  assign b0.hready = b0.hreadyout;
  assign b2.hready = b2.hreadyout;

  ahb5_sram_excl_responder #(
    .W_ADDR(32), .W_DATA(32), .DEPTH(1024), .WAIT_CYCLES(0), .N_MONITORS(2)
  ) dut0 (.clk(clk), .rst(rst), .ahb(b0));

  ahb5_sram_excl_responder #(
    .W_ADDR(32), .W_DATA(32), .DEPTH(1024), .WAIT_CYCLES(2), .N_MONITORS(2)
  ) dut2 (.clk(clk), .rst(rst), .ahb(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    b0.hsel = 1'b0; b0.htrans = HTRANS_IDLE; b0.hexcl = 1'b0;
  endtask

  task automatic addr0(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic ex, input logic [7:0] m);
    b0.hsel = 1'b1; b0.htrans = HTRANS_NSEQ; b0.hwrite = wr; b0.haddr = a;
    b0.hsize = sz; b0.hexcl = ex; b0.hmaster = m;
  endtask

  // Single transfer on the zero-wait instance; checks its data phase.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] a,
                      input logic ex, input logic [7:0] m, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_xok);
    tick();
    addr0(wr, a, HSIZE_WORD, ex, m);
    tick();
    idle0();
    b0.hwdata = wd;
    check({tag, "_rdy"}, 32'(b0.hreadyout), 32'd1);
    check({tag, "_resp"}, 32'(b0.hresp), 32'd0);
    check({tag, "_xok"}, 32'(b0.hexokay), 32'(exp_xok));
    if (!wr) check({tag, "_rdata"}, b0.hrdata, exp_rd);
  endtask

  task automatic err_xfer(input string tag, input logic [31:0] a, input logic [2:0] sz);
    tick();
    addr0(1'b1, a, sz, 1'b0, 8'd0);
    tick();
    idle0();
    b0.hwdata = 32'h0BAD0BAD;
    check({tag, "_c1_rdy"}, 32'(b0.hreadyout), 32'd0);
    check({tag, "_c1_resp"}, 32'(b0.hresp), 32'd1);
    tick();
    check({tag, "_c2_rdy"}, 32'(b0.hreadyout), 32'd1);
    check({tag, "_c2_resp"}, 32'(b0.hresp), 32'd1);
    check({tag, "_c2_xok"}, 32'(b0.hexokay), 32'd0);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lows;
    idle0();
    b0.hwrite = 1'b0; b0.haddr = '0; b0.hsize = HSIZE_WORD; b0.hmaster = '0; b0.hwdata = '0;
    b2.hsel = 1'b0; b2.htrans = HTRANS_IDLE; b2.hwrite = 1'b0; b2.haddr = '0;
    b2.hsize = HSIZE_WORD; b2.hexcl = 1'b0; b2.hmaster = '0; b2.hwdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rdy", 32'(b0.hreadyout), 32'd1);
    check("rst_resp", 32'(b0.hresp), 32'd0);
    check("rst_xok", 32'(b0.hexokay), 32'd0);
    check("rst_rdata", b0.hrdata, 32'd0);
    check("rst_rdy_w2", 32'(b2.hreadyout), 32'd1);

    // Store then load back-to-back: forwarded data, no stalls.
    tick();
    addr0(1'b1, 32'h10, HSIZE_WORD, 1'b0, 8'd0);
    tick();
    b0.hwdata = 32'hDEADBEEF;
    addr0(1'b0, 32'h10, HSIZE_WORD, 1'b0, 8'd0);
    check("b2b_wr_rdy", 32'(b0.hreadyout), 32'd1);
    tick();
    idle0();
    check("b2b_rd_rdy", 32'(b0.hreadyout), 32'd1);
    check("b2b_rd_data", b0.hrdata, 32'hDEADBEEF);

    // Byte lane 3 store over a full word, then pipelined load.
    tick();
    addr0(1'b1, 32'h10, HSIZE_WORD, 1'b0, 8'd0);
    tick();
    b0.hwdata = 32'h11223344;
    addr0(1'b1, 32'h13, HSIZE_BYTE, 1'b0, 8'd0);
    tick();
    b0.hwdata = 32'hAA000000;
    addr0(1'b0, 32'h10, HSIZE_WORD, 1'b0, 8'd0);
    tick();
    idle0();
    check("byte_merge", b0.hrdata, 32'hAA223344);
    xfer("byte_reread", 1'b0, 32'h10, 1'b0, 8'd0, 32'd0, 32'hAA223344, 1'b0);

    // Error responses leave word 0 untouched.
    xfer("e_init", 1'b1, 32'h00, 1'b0, 8'd0, 32'hCAFEF00D, 32'd0, 1'b0);
    err_xfer("err_half", 32'h01, HSIZE_HALF);
    err_xfer("err_oob", 32'h1000, HSIZE_WORD);
    err_xfer("err_size", 32'h00, 3'd3);
    xfer("e_chk", 1'b0, 32'h00, 1'b0, 8'd0, 32'd0, 32'hCAFEF00D, 1'b0);

    // Exclusive pass, then repeat fails.
    xfer("x_init", 1'b1, 32'h20, 1'b0, 8'd0, 32'h0, 32'd0, 1'b0);
    xfer("x_rd", 1'b0, 32'h20, 1'b1, 8'd0, 32'd0, 32'h0, 1'b1);
    xfer("x_wr", 1'b1, 32'h20, 1'b1, 8'd0, 32'h55, 32'd0, 1'b1);
    xfer("x_wr_again", 1'b1, 32'h20, 1'b1, 8'd0, 32'h66, 32'd0, 1'b0);
    xfer("x_chk1", 1'b0, 32'h20, 1'b0, 8'd0, 32'd0, 32'h55, 1'b0);

    // Another manager's plain store breaks the reservation.
    xfer("x_rd2", 1'b0, 32'h20, 1'b1, 8'd0, 32'd0, 32'h55, 1'b1);
    xfer("x_m1_wr", 1'b1, 32'h20, 1'b0, 8'd1, 32'h77, 32'd0, 1'b0);
    xfer("x_lost", 1'b1, 32'h20, 1'b1, 8'd0, 32'h99, 32'd0, 1'b0);
    xfer("x_chk2", 1'b0, 32'h20, 1'b0, 8'd0, 32'd0, 32'h77, 1'b0);

    // Independent reservations; a failed exclusive store does not clear others.
    xfer("i_init", 1'b1, 32'h24, 1'b0, 8'd1, 32'h100, 32'd0, 1'b0);
    xfer("i_rd_m0", 1'b0, 32'h20, 1'b1, 8'd0, 32'd0, 32'h77, 1'b1);
    xfer("i_rd_m1", 1'b0, 32'h24, 1'b1, 8'd1, 32'd0, 32'h100, 1'b1);
    xfer("i_wr_m1", 1'b1, 32'h24, 1'b1, 8'd1, 32'h200, 32'd0, 1'b1);
    xfer("i_bad_m1", 1'b1, 32'h20, 1'b1, 8'd1, 32'hEE, 32'd0, 1'b0);
    xfer("i_wr_m0", 1'b1, 32'h20, 1'b1, 8'd0, 32'h88, 32'd0, 1'b1);
    xfer("i_chk20", 1'b0, 32'h20, 1'b0, 8'd0, 32'd0, 32'h88, 1'b0);
    xfer("i_chk24", 1'b0, 32'h24, 1'b0, 8'd0, 32'd0, 32'h200, 1'b0);

    // Reset drops reservations.
    xfer("r_rd", 1'b0, 32'h20, 1'b1, 8'd0, 32'd0, 32'h88, 1'b1);
    pulse_reset();
    xfer("r_wr", 1'b1, 32'h20, 1'b1, 8'd0, 32'hAB, 32'd0, 1'b0);
    xfer("r_chk", 1'b0, 32'h20, 1'b0, 8'd0, 32'd0, 32'h88, 1'b0);

    // Reset during a write data phase discards the write.
    xfer("m_init", 1'b1, 32'h30, 1'b0, 8'd0, 32'h1234, 32'd0, 1'b0);
    tick();
    addr0(1'b1, 32'h30, HSIZE_WORD, 1'b0, 8'd0);
    tick();
    idle0();
    b0.hwdata = 32'hBAD;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("m_rst_rdy", 32'(b0.hreadyout), 32'd1);
    check("m_rst_xok", 32'(b0.hexokay), 32'd0);
    xfer("m_chk", 1'b0, 32'h30, 1'b0, 8'd0, 32'd0, 32'h1234, 1'b0);

    // Two wait states: write, then read accepted in the completing cycle.
    tick();
    b2.hsel = 1'b1; b2.htrans = HTRANS_NSEQ; b2.hwrite = 1'b1; b2.haddr = 32'h40;
    tick();
    b2.hsel = 1'b0; b2.htrans = HTRANS_IDLE; b2.hwdata = 32'h5A5A1234;
    lows = 0;
    while (!b2.hreadyout && lows < 20) begin
      lows++;
      tick();
    end
    check("w2_wr_lows", 32'(lows), 32'd2);
    check("w2_wr_resp", 32'(b2.hresp), 32'd0);
    b2.hsel = 1'b1; b2.htrans = HTRANS_NSEQ; b2.hwrite = 1'b0; b2.haddr = 32'h40;
    tick();
    b2.hsel = 1'b0; b2.htrans = HTRANS_IDLE;
    check("w2_hold", b2.hrdata, 32'd0);
    lows = 0;
    while (!b2.hreadyout && lows < 20) begin
      lows++;
      tick();
    end
    check("w2_rd_lows", 32'(lows), 32'd2);
    check("w2_rd_rdy", 32'(b2.hreadyout), 32'd1);
    check("w2_rd_data", b2.hrdata, 32'h5A5A1234);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
